// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
//   Conditions raw active-low pushbuttons for downstream sequential logic.
//   Each key is synchronised to Clk, inverted, and debounced by its own
//   four-state counter FSM (UP / WAIT_DN / DOWN / WAIT_UP). The outputs are a
//   clean active-high level and single-cycle press pulses. Release pulses are
//   optional.
//
// Optional feature macro: DEBOUNCE_RELEASE_PULSE_EN
//   defined   : Release[i] pulses for one cycle on the WAIT_UP -> UP transition.
//   undefined : Release is tied to 0 and no release logic is built.
//
// Ports
//   Clk      in   1       system clock
//   Rst      in   1       synchronous, active-high reset
//   KEY      in   N_KEYS  raw pushbuttons, active-low, asynchronous to Clk
//   Level    out  N_KEYS  debounced state, active-high (1 = pressed)
//   Press    out  N_KEYS  one-cycle pulse when Level rises
//   Release  out  N_KEYS  one-cycle pulse when Level falls (macro-gated)
//
// The per-key FSM state is held in state_q (a packed array of state_e), so
// checkers can bind to it hierarchically.
module key_debounce_pulse #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] Level,
  output logic [N_KEYS-1:0] Press,
  output logic [N_KEYS-1:0] Release
);

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_WAIT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_WAIT_UP = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] s;  // synchronised key, 1 = pressed

  state_e [N_KEYS-1:0]                state_q, state_d;
  logic   [N_KEYS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic [N_KEYS-1:0] release_q, release_d;
`endif

  assign s = ~sync2_q;

  // State register. The synchroniser resets to 1 so that a key held through
  // reset is seen as a fresh press once reset is released.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      state_q   <= {N_KEYS{ST_UP}};
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      release_q <= '0;
`endif
    end else begin
      sync1_q   <= KEY;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  // Next-state logic. The counter never wraps: reaching CNT_MAX always forces
  // the transition out of the WAIT state in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_KEYS; i++) begin
      case (state_q[i])
        ST_UP: begin
          if (s[i]) begin
            state_d[i] = ST_WAIT_DN;
            cnt_d[i]   = '0;
          end
        end
        ST_WAIT_DN: begin
          if (!s[i]) begin
            state_d[i] = ST_UP;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = ST_DOWN;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
        ST_DOWN: begin
          if (!s[i]) begin
            state_d[i] = ST_WAIT_UP;
            cnt_d[i]   = '0;
          end
        end
        ST_WAIT_UP: begin
          if (s[i]) begin
            state_d[i] = ST_DOWN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = ST_UP;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d[i] = ST_UP;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output logic. The outputs are computed from the next state and then
  // registered, so Level and Press change on the same edge as the state.
  always_comb begin
    level_d   = '0;
    press_d   = '0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    release_d = '0;
`endif
    for (int i = 0; i < N_KEYS; i++) begin
      level_d[i]   = (state_d[i] == ST_DOWN) || (state_d[i] == ST_WAIT_UP);
      press_d[i]   = (state_q[i] == ST_WAIT_DN) && (state_d[i] == ST_DOWN);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      release_d[i] = (state_q[i] == ST_WAIT_UP) && (state_d[i] == ST_UP);
`endif
    end
  end

  assign Level = level_q;
  assign Press = press_q;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  assign Release = release_q;
`else
  assign Release = '0;
`endif

endmodule

// File: tb/tb_key_debounce_pulse.sv
module tb_key_debounce_pulse;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int CW = 3;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [N-1:0] KEY = 3'b111;
  logic [N-1:0] Level, Press, Release;

  key_debounce_pulse #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .KEY(KEY),
    .Level(Level), .Press(Press), .Release(Release)
  );

  // clock
  always #5 Clk = ~Clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] key;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic [N-1:0] k);
    @(negedge Clk);
    Rst = r;
    KEY = k;
    @(posedge Clk);
    #1;
    check("press_and_release_exclusive", Press & Release, 3'b000);
  endtask

  task automatic add_rows(input int n, input logic r, input logic [N-1:0] k,
                          input logic [N-1:0] l, input logic [N-1:0] p,
                          input logic [N-1:0] rl);
    vec_t v;
    v.rst = r; v.key = k; v.lvl = l; v.prs = p; v.rel = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    logic [N-1:0] rel0;
    logic [N-1:0] exp_l, exp_p, exp_r;
    rel0 = REL_EN ? 3'b001 : 3'b000;

    // Table: reset, key 0 press (7-edge latency), then key 0 release.
    add_rows(2, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);  // reset with keys low
    add_rows(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);  // idle
    add_rows(6, 1'b0, 3'b110, 3'b000, 3'b000, 3'b000);  // key0 falls, edges 1..6
    add_rows(1, 1'b0, 3'b110, 3'b001, 3'b001, 3'b000);  // edge 7: level + press
    add_rows(2, 1'b0, 3'b110, 3'b001, 3'b000, 3'b000);  // held
    add_rows(6, 1'b0, 3'b111, 3'b001, 3'b000, 3'b000);  // key0 released, edges 1..6
    add_rows(1, 1'b0, 3'b111, 3'b000, 3'b000, rel0);    // edge 7: level drops
    add_rows(2, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].key);
      check($sformatf("table[%0d].level", i),   Level,   vecs[i].lvl);
      check($sformatf("table[%0d].press", i),   Press,   vecs[i].prs);
      check($sformatf("table[%0d].release", i), Release, vecs[i].rel);
    end

    // Key 1 bounces with 2-cycle pulses, then is held low.
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b0, (t % 2 == 0) ? 3'b101 : 3'b111);
        check("bounce.press", Press, 3'b000);
        check("bounce.level", Level, 3'b000);
      end
    end
    for (int s = 1; s <= 9; s++) begin
      step(1'b0, 3'b101);
      exp_p = (s == 7) ? 3'b010 : 3'b000;
      exp_l = (s >= 7) ? 3'b010 : 3'b000;
      check($sformatf("bounce_hold[%0d].press", s), Press, exp_p);
      check($sformatf("bounce_hold[%0d].level", s), Level, exp_l);
    end
    repeat (8) step(1'b0, 3'b111);
    check("bounce_release.level", Level, 3'b000);

    // Reset in the middle of a key 2 debounce, with the key held throughout.
    for (int s = 0; s < 2; s++) begin
      step(1'b0, 3'b011);
      check("mid_rst_pre.press", Press, 3'b000);
    end
    for (int s = 0; s < 2; s++) begin
      step(1'b1, 3'b011);
      check("mid_rst.level", Level, 3'b000);
      check("mid_rst.press", Press, 3'b000);
    end
    for (int s = 1; s <= 8; s++) begin
      step(1'b0, 3'b011);
      exp_p = (s == 7) ? 3'b100 : 3'b000;
      exp_l = (s >= 7) ? 3'b100 : 3'b000;
      check($sformatf("post_rst[%0d].press", s), Press, exp_p);
      check($sformatf("post_rst[%0d].level", s), Level, exp_l);
    end
    repeat (8) step(1'b0, 3'b111);
    check("post_rst_release.level", Level, 3'b000);

    // All three keys pressed in the same cycle, then all released.
    for (int s = 1; s <= 9; s++) begin
      step(1'b0, 3'b000);
      exp_p = (s == 7) ? 3'b111 : 3'b000;
      exp_l = (s >= 7) ? 3'b111 : 3'b000;
      check($sformatf("all_press[%0d].press", s), Press, exp_p);
      check($sformatf("all_press[%0d].level", s), Level, exp_l);
    end
    for (int s = 1; s <= 8; s++) begin
      step(1'b0, 3'b111);
      exp_l = (s >= 7) ? 3'b000 : 3'b111;
      exp_r = (REL_EN && s == 7) ? 3'b111 : 3'b000;
      check($sformatf("all_release[%0d].level", s),   Level,   exp_l);
      check($sformatf("all_release[%0d].release", s), Release, exp_r);
      check($sformatf("all_release[%0d].press", s),   Press,   3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
